colormem_writer: RTL and testbench

COLORMEM_WRITER -- requirements
Module: colormem_writer

---
 rtl/xosera_pkg.sv | 13 +
 rtl/colormem_writer.sv | 161 ++++++++++++++++
 tb/tb_colormem_writer.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xosera_pkg.sv
// Shared definitions for the colour-memory writer: controller state
// encoding and the colour-entry width.
package xosera_pkg;

   localparam int COLOR_W = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_WAIT = 2'd1,
      FILL      = 2'd2
   } cmw_state_t;

endpackage

// File: rtl/colormem_writer.sv
// Colour-memory access controller. Serialises single CPU reads/writes and
// an optional block-fill engine onto the colour memory's write and read
// ports. The memory itself lives in the parent; its read port returns data
// one clock after cm_rd_en_o is seen.
//
// Build option: define COLORMEM_FILL_EN to include the block-fill engine.
// Without it the fill_* inputs are ignored and fill_busy_o is tied low.
module colormem_writer
   import xosera_pkg::*;
#(
   parameter int AWIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_write_i,
   input  logic [AWIDTH-1:0]    req_addr_i,
   input  logic [COLOR_W-1:0]   req_data_i,
   output logic                 rd_valid_o,
   output logic [COLOR_W-1:0]   rd_data_o,
   input  logic                 fill_start_i,
   input  logic [AWIDTH-1:0]    fill_addr_i,
   input  logic [AWIDTH:0]      fill_count_i,
   input  logic [COLOR_W-1:0]   fill_data_i,
   input  logic                 fill_incr_i,
   output logic                 fill_busy_o,
   output logic                 cm_wr_en_o,
   output logic [AWIDTH-1:0]    cm_wr_addr_o,
   output logic [COLOR_W-1:0]   cm_wr_data_o,
   output logic                 cm_rd_en_o,
   output logic [AWIDTH-1:0]    cm_rd_addr_o,
   input  logic [COLOR_W-1:0]   cm_rd_data_i
);

   cmw_state_t           state_q;
   logic                 wrEn_q;
   logic [AWIDTH-1:0]    wrAddr_q;
   logic [COLOR_W-1:0]   wrData_q;
   logic                 rdEn_q;
   logic [AWIDTH-1:0]    rdAddr_q;
   logic                 rdValid_q;
   logic [COLOR_W-1:0]   rdHold_q;
   logic                 reqFire;

`ifdef COLORMEM_FILL_EN
   localparam logic [AWIDTH-1:0] ADDR_ONE  = AWIDTH'(1);
   localparam logic [AWIDTH:0]   COUNT_ONE = (AWIDTH+1)'(1);

   logic                 fillBusy_q;
   logic [AWIDTH-1:0]    fillAddr_q;
   logic [COLOR_W-1:0]   fillData_q;
   logic                 fillIncr_q;
   logic [AWIDTH:0]      fillLeft_q;
   logic                 fillGo;

   // A pending fill command blocks CPU requests so the fill always wins
   assign req_ready_o = !reset_i && (state_q == IDLE) && !fill_start_i;
   assign fillGo      = (state_q == IDLE) && fill_start_i && (fill_count_i != '0);
   assign fill_busy_o = fillBusy_q;
`else
   logic                 unusedFill;

   assign req_ready_o = !reset_i && (state_q == IDLE);
   assign fill_busy_o = 1'b0;
   assign unusedFill  = ^{fill_start_i, fill_addr_i, fill_count_i, fill_data_i, fill_incr_i};
`endif

   assign reqFire = req_valid_i && req_ready_o;

   // Read data is presented straight from the memory port during the
   // rd_valid_o cycle, then held from the captured copy until the next read.
   assign rd_valid_o   = rdValid_q;
   assign rd_data_o    = rdValid_q ? cm_rd_data_i : rdHold_q;
   assign cm_wr_en_o   = wrEn_q;
   assign cm_wr_addr_o = wrAddr_q;
   assign cm_wr_data_o = wrData_q;
   assign cm_rd_en_o   = rdEn_q;
   assign cm_rd_addr_o = rdAddr_q;

   // Controller FSM with registered memory strobes; strobes default low so
   // every write/read/valid is a single-cycle pulse unless re-issued.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         wrEn_q     <= 1'b0;
         wrAddr_q   <= '0;
         wrData_q   <= '0;
         rdEn_q     <= 1'b0;
         rdAddr_q   <= '0;
         rdValid_q  <= 1'b0;
         rdHold_q   <= '0;
`ifdef COLORMEM_FILL_EN
         fillBusy_q <= 1'b0;
         fillAddr_q <= '0;
         fillData_q <= '0;
         fillIncr_q <= 1'b0;
         fillLeft_q <= '0;
`endif
      end else begin
         wrEn_q    <= 1'b0;
         rdEn_q    <= 1'b0;
         rdValid_q <= 1'b0;
         if (rdValid_q) begin
            rdHold_q <= cm_rd_data_i;
         end
         case (state_q)
            IDLE: begin
`ifdef COLORMEM_FILL_EN
               if (fillGo) begin
                  // First entry goes out immediately; registers hold the next one
                  state_q    <= FILL;
                  fillBusy_q <= 1'b1;
                  wrEn_q     <= 1'b1;
                  wrAddr_q   <= fill_addr_i;
                  wrData_q   <= fill_data_i;
                  fillAddr_q <= fill_addr_i + ADDR_ONE;
                  fillData_q <= fill_data_i + {{(COLOR_W-1){1'b0}}, fill_incr_i};
                  fillIncr_q <= fill_incr_i;
                  fillLeft_q <= fill_count_i - COUNT_ONE;
               end else
`endif
               if (reqFire) begin
                  if (req_write_i) begin
                     wrEn_q   <= 1'b1;
                     wrAddr_q <= req_addr_i;
                     wrData_q <= req_data_i;
                  end else begin
                     rdEn_q   <= 1'b1;
                     rdAddr_q <= req_addr_i;
                     state_q  <= READ_WAIT;
                  end
               end
            end
            READ_WAIT: begin
               rdValid_q <= 1'b1;
               state_q   <= IDLE;
            end
`ifdef COLORMEM_FILL_EN
            FILL: begin
               if (fillLeft_q == '0) begin
                  fillBusy_q <= 1'b0;
                  state_q    <= IDLE;
               end else begin
                  wrEn_q     <= 1'b1;
                  wrAddr_q   <= fillAddr_q;
                  wrData_q   <= fillData_q;
                  fillAddr_q <= fillAddr_q + ADDR_ONE;
                  fillData_q <= fillData_q + {{(COLOR_W-1){1'b0}}, fillIncr_q};
                  fillLeft_q <= fillLeft_q - COUNT_ONE;
               end
            end
`endif
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_colormem_writer.sv
// Scoreboard bench for colormem_writer: stimulus pushes expected memory
// writes, read strobes and read results; a negedge monitor pops and compares
// them (value and cycle). Fill checks depend on COLORMEM_FILL_EN.
module tb_colormem_writer;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          req_valid_i;
   logic          req_ready_o;
   logic          req_write_i;
   logic [AW-1:0] req_addr_i;
   logic [15:0]   req_data_i;
   logic          rd_valid_o;
   logic [15:0]   rd_data_o;
   logic          fill_start_i;
   logic [AW-1:0] fill_addr_i;
   logic [AW:0]   fill_count_i;
   logic [15:0]   fill_data_i;
   logic          fill_incr_i;
   logic          fill_busy_o;
   logic          cm_wr_en_o;
   logic [AW-1:0] cm_wr_addr_o;
   logic [15:0]   cm_wr_data_o;
   logic          cm_rd_en_o;
   logic [AW-1:0] cm_rd_addr_o;
   logic [15:0]   cm_rd_data_i;

   int checkCount = 0;
   int errorCount = 0;
   int cyc = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [15:0]   data;
      int            cyc;
   } ev_t;

   ev_t wrQ[$];
   ev_t rdAddrQ[$];
   ev_t rdDataQ[$];
   ev_t monE;

   logic [15:0] mem [0:255];
   logic [15:0] memRd;

   colormem_writer #(.AWIDTH(AW)) dut (
      .clk          (clk),
      .reset_i      (reset_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_write_i  (req_write_i),
      .req_addr_i   (req_addr_i),
      .req_data_i   (req_data_i),
      .rd_valid_o   (rd_valid_o),
      .rd_data_o    (rd_data_o),
      .fill_start_i (fill_start_i),
      .fill_addr_i  (fill_addr_i),
      .fill_count_i (fill_count_i),
      .fill_data_i  (fill_data_i),
      .fill_incr_i  (fill_incr_i),
      .fill_busy_o  (fill_busy_o),
      .cm_wr_en_o   (cm_wr_en_o),
      .cm_wr_addr_o (cm_wr_addr_o),
      .cm_wr_data_o (cm_wr_data_o),
      .cm_rd_en_o   (cm_rd_en_o),
      .cm_rd_addr_o (cm_rd_addr_o),
      .cm_rd_data_i (cm_rd_data_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Colour memory model: one-cycle read latency, junk when not reading
   always @(posedge clk) begin
      if (cm_wr_en_o) mem[cm_wr_addr_o] <= cm_wr_data_o;
      memRd <= cm_rd_en_o ? mem[cm_rd_addr_o] : 16'hDEAD;
   end
   assign cm_rd_data_i = memRd;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: every strobe the DUT presents must match the head of its queue
   always @(negedge clk) begin
      if (!reset_i) begin
         if (cm_wr_en_o) begin
            if (wrQ.size() == 0) begin
               checkCount++;
               errorCount++;
               $display("[TB] FAIL wr_unexpected: actual write addr 0x%0h data 0x%0h at cycle %0d, expected none",
                        cm_wr_addr_o, cm_wr_data_o, cyc);
            end else begin
               monE = wrQ.pop_front();
               checkOutput("wr_addr", 32'(cm_wr_addr_o), 32'(monE.addr));
               checkOutput("wr_data", 32'(cm_wr_data_o), 32'(monE.data));
               checkOutput("wr_cycle", 32'(cyc), 32'(monE.cyc));
            end
         end
         if (cm_rd_en_o) begin
            if (rdAddrQ.size() == 0) begin
               checkCount++;
               errorCount++;
               $display("[TB] FAIL rd_en_unexpected: actual read addr 0x%0h at cycle %0d, expected none", cm_rd_addr_o, cyc);
            end else begin
               monE = rdAddrQ.pop_front();
               checkOutput("rd_addr", 32'(cm_rd_addr_o), 32'(monE.addr));
               checkOutput("rd_en_cycle", 32'(cyc), 32'(monE.cyc));
            end
         end
         if (rd_valid_o) begin
            if (rdDataQ.size() == 0) begin
               checkCount++;
               errorCount++;
               $display("[TB] FAIL rd_valid_unexpected: actual data 0x%0h at cycle %0d, expected none", rd_data_o, cyc);
            end else begin
               monE = rdDataQ.pop_front();
               checkOutput("rd_data", 32'(rd_data_o), 32'(monE.data));
               checkOutput("rd_valid_cycle", 32'(cyc), 32'(monE.cyc));
            end
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pushWr(input logic [AW-1:0] addr, input logic [15:0] data, input int atCyc);
      ev_t e;
      e.addr = addr;
      e.data = data;
      e.cyc  = atCyc;
      wrQ.push_back(e);
   endtask

   // Issue one CPU request, hold it until accepted (bounded), push expectations
   task automatic applyStimulus(input logic isWrite, input logic [AW-1:0] addr, input logic [15:0] data,
                                input logic [15:0] expRd, input bit pushExp, output int acceptCyc);
      int budget;
      bit accepted;
      ev_t e;
      budget = 0;
      accepted = 1'b0;
      acceptCyc = -1;
      req_valid_i = 1'b1;
      req_write_i = isWrite;
      req_addr_i  = addr;
      req_data_i  = data;
      while (!accepted && budget < 64) begin
         @(negedge clk);
         accepted = req_ready_o;
         @(posedge clk);
         #1;
         budget++;
      end
      req_valid_i = 1'b0;
      if (!accepted) begin
         checkCount++;
         errorCount++;
         $display("[TB] FAIL req_timeout: actual no acceptance in 64 cycles, expected acceptance (addr 0x%0h)", addr);
      end else begin
         acceptCyc = cyc;
         if (pushExp) begin
            if (isWrite) begin
               pushWr(addr, data, acceptCyc);
            end else begin
               e.addr = addr; e.data = 16'h0;  e.cyc = acceptCyc;     rdAddrQ.push_back(e);
               e.addr = addr; e.data = expRd;  e.cyc = acceptCyc + 1; rdDataQ.push_back(e);
            end
         end
      end
   endtask

   task automatic applyFill(input logic [AW-1:0] addr, input logic [AW:0] count, input logic [15:0] data,
                            input logic incr, output int startCyc);
      fill_addr_i  = addr;
      fill_count_i = count;
      fill_data_i  = data;
      fill_incr_i  = incr;
      fill_start_i = 1'b1;
      @(posedge clk);
      #1;
      fill_start_i = 1'b0;
      startCyc = cyc;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int ac;
      int sc;
      int j;
      int busyCnt;
      reset_i      = 1'b1;
      req_valid_i  = 1'b0;
      req_write_i  = 1'b0;
      req_addr_i   = '0;
      req_data_i   = '0;
      fill_start_i = 1'b0;
      fill_addr_i  = '0;
      fill_count_i = '0;
      fill_data_i  = '0;
      fill_incr_i  = 1'b0;

      waitCycles(3);
      checkOutput("rst_wr_en",    32'(cm_wr_en_o),   32'h0);
      checkOutput("rst_wr_addr",  32'(cm_wr_addr_o), 32'h0);
      checkOutput("rst_wr_data",  32'(cm_wr_data_o), 32'h0);
      checkOutput("rst_rd_en",    32'(cm_rd_en_o),   32'h0);
      checkOutput("rst_rd_valid", 32'(rd_valid_o),   32'h0);
      checkOutput("rst_rd_data",  32'(rd_data_o),    32'h0);
      checkOutput("rst_busy",     32'(fill_busy_o),  32'h0);
      checkOutput("rst_ready",    32'(req_ready_o),  32'h0);
      reset_i = 1'b0;
      #1;
      checkOutput("ready_after_reset", 32'(req_ready_o), 32'h1);
      waitCycles(1);

      // Single write then read-back of the same entry
      applyStimulus(1'b1, 8'h12, 16'hABCD, 16'h0, 1'b1, ac);
      applyStimulus(1'b0, 8'h12, 16'h0, 16'hABCD, 1'b1, ac);
      checkOutput("ready_in_read_wait", 32'(req_ready_o), 32'h0);

      // Back-to-back writes at the address extremes, then reads
      applyStimulus(1'b1, 8'h00, 16'h0000, 16'h0, 1'b1, ac);
      applyStimulus(1'b1, 8'hFF, 16'hFFFF, 16'h0, 1'b1, ac);
      applyStimulus(1'b1, 8'h55, 16'h5A5A, 16'h0, 1'b1, ac);
      applyStimulus(1'b0, 8'hFF, 16'h0, 16'hFFFF, 1'b1, ac);
      applyStimulus(1'b0, 8'h00, 16'h0, 16'h0000, 1'b1, ac);
      applyStimulus(1'b0, 8'h55, 16'h0, 16'h5A5A, 1'b1, ac);
      waitCycles(4);
      checkOutput("rd_hold", 32'(rd_data_o), 32'h5A5A);
      checkOutput("rd_valid_idle", 32'(rd_valid_o), 32'h0);

      applyStimulus(1'b1, 8'h12, 16'h1234, 16'h0, 1'b1, ac);
      applyStimulus(1'b0, 8'h12, 16'h0, 16'h1234, 1'b1, ac);

      // Reset in READ_WAIT aborts the read: no rd_valid pulse follows
      waitCycles(2);
      applyStimulus(1'b0, 8'h12, 16'h0, 16'h0, 1'b0, ac);
      reset_i = 1'b1;
      #1;
      checkOutput("abort_rd_en", 32'(cm_rd_en_o), 32'h0);
      checkOutput("abort_rd_data", 32'(rd_data_o), 32'h0);
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      waitCycles(4);
      checkOutput("abort_rd_data_held", 32'(rd_data_o), 32'h0);
      applyStimulus(1'b0, 8'h12, 16'h0, 16'h1234, 1'b1, ac);

      // Zero-count fill is a no-op
      applyFill(8'h00, 9'd0, 16'hEEEE, 1'b1, sc);
      checkOutput("fill0_busy", 32'(fill_busy_o), 32'h0);
      waitCycles(3);
      applyStimulus(1'b0, 8'h00, 16'h0, 16'h0000, 1'b1, ac);

      // Fill and request together: fill wins when the engine exists
      waitCycles(2);
      j = cyc;
      fill_addr_i  = 8'h20;
      fill_count_i = 9'd5;
      fill_data_i  = 16'h0A0A;
      fill_incr_i  = 1'b0;
      fill_start_i = 1'b1;
      fork
         begin
            @(posedge clk);
            #1;
            fill_start_i = 1'b0;
         end
      join_none
`ifdef COLORMEM_FILL_EN
      for (int i = 0; i < 5; i++) pushWr(8'h20 + 8'(i), 16'h0A0A, j + 1 + i);
      applyStimulus(1'b1, 8'h30, 16'hC3C3, 16'h0, 1'b1, ac);
      checkOutput("req_after_fill", 32'(ac), 32'(j + 7));
      applyStimulus(1'b0, 8'h22, 16'h0, 16'h0A0A, 1'b1, ac);
`else
      applyStimulus(1'b1, 8'h30, 16'hC3C3, 16'h0, 1'b1, ac);
      checkOutput("req_fill_ignored", 32'(ac), 32'(j + 1));
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("busy_tied_low", 32'(fill_busy_o), 32'h0);
      end
      waitCycles(1);
`endif
      applyStimulus(1'b0, 8'h30, 16'h0, 16'hC3C3, 1'b1, ac);

`ifdef COLORMEM_FILL_EN
      // Fill wrapping the address with incrementing data
      waitCycles(2);
      applyFill(8'hFE, 9'd4, 16'h0100, 1'b1, sc);
      pushWr(8'hFE, 16'h0100, sc);
      pushWr(8'hFF, 16'h0101, sc + 1);
      pushWr(8'h00, 16'h0102, sc + 2);
      pushWr(8'h01, 16'h0103, sc + 3);
      busyCnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (fill_busy_o) busyCnt++;
      end
      checkOutput("fill_busy_cycles", 32'(busyCnt), 32'd4);
      waitCycles(1);
      applyStimulus(1'b0, 8'h00, 16'h0, 16'h0102, 1'b1, ac);
      applyStimulus(1'b0, 8'h01, 16'h0, 16'h0103, 1'b1, ac);
      applyStimulus(1'b0, 8'hFF, 16'h0, 16'h0101, 1'b1, ac);

      // Constant-data fill
      applyFill(8'h40, 9'd3, 16'h7777, 1'b0, sc);
      pushWr(8'h40, 16'h7777, sc);
      pushWr(8'h41, 16'h7777, sc + 1);
      pushWr(8'h42, 16'h7777, sc + 2);
      waitCycles(5);
      applyStimulus(1'b0, 8'h42, 16'h0, 16'h7777, 1'b1, ac);

      // Full-table fill with data wrapping past 0xFFFF
      applyFill(8'h10, 9'd256, 16'hFFFE, 1'b1, sc);
      for (int i = 0; i < 256; i++) pushWr(8'h10 + 8'(i), 16'hFFFE + 16'(i), sc + i);
      waitCycles(260);
      applyStimulus(1'b0, 8'h0F, 16'h0, 16'h00FD, 1'b1, ac);
      applyStimulus(1'b0, 8'h12, 16'h0, 16'h0000, 1'b1, ac);

      // Reset after 2 of 8 fill writes
      applyFill(8'h80, 9'd8, 16'h1000, 1'b1, sc);
      pushWr(8'h80, 16'h1000, sc);
      pushWr(8'h81, 16'h1001, sc + 1);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      reset_i = 1'b1;
      #1;
      checkOutput("midfill_wr_en", 32'(cm_wr_en_o), 32'h0);
      checkOutput("midfill_busy", 32'(fill_busy_o), 32'h0);
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      #1;
      checkOutput("midfill_idle_ready", 32'(req_ready_o), 32'h1);
      waitCycles(10);
      checkOutput("midfill_busy_after", 32'(fill_busy_o), 32'h0);
      applyStimulus(1'b0, 8'h81, 16'h0, 16'h1001, 1'b1, ac);
      applyStimulus(1'b0, 8'h82, 16'h0, 16'h0070, 1'b1, ac);
`endif

      waitCycles(5);
      checkOutput("wr_queue_drained", 32'(wrQ.size()), 32'd0);
      checkOutput("rd_en_queue_drained", 32'(rdAddrQ.size()), 32'd0);
      checkOutput("rd_data_queue_drained", 32'(rdDataQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
